hv_reg_acc_arb: RTL and testbench
=================================

HV_REG_ACC_ARB -- requirements
Module: hv_reg_acc_arb

Interface
REQ-001 The block SHALL have parameter REG_AW, default 7, meaning register address width.
REQ-002 The block SHALL have parameter REG_DW, default 8, meaning register data width.
REQ-003 The block SHALL have parameter REG_CRC_W, default 8, meaning response CRC width.
REQ-004 The block SHALL have parameter ACK_TMO_TH, default 16, meaning the number of BUSY cycles after which a missing bank acknowledge counts as a timeout.
REQ-005 The block SHALL have parameter STARVE_TH, default 4, meaning the number of consecutive OWT grants after which a pending WDG request is forced.
REQ-006 The block SHALL have ports: i_clk in 1 clock; i_rst_n in 1 reset, asynchronous, active-low.
REQ-007 The block SHALL have OWT ports: i_owt_rac_wr_req in 1; i_owt_rac_rd_req in 1; i_owt_rac_addr in REG_AW; i_owt_rac_wdata in REG_DW; o_rac_owt_ack out 1; o_rac_owt_rdata out REG_DW.
REQ-008 The block SHALL have WDG scan ports: i_wdg_scan_rac_rd_req in 1; i_wdg_scan_rac_addr in REG_AW; o_rac_wdg_scan_ack out 1; o_rac_wdg_scan_data out REG_DW; o_rac_wdg_scan_crc out REG_CRC_W.
REQ-009 The block SHALL have register-bank ports: o_rac_reg_wr_en out 1; o_rac_reg_rd_en out 1; o_rac_reg_addr out REG_AW; o_rac_reg_wdata out REG_DW; i_reg_rac_ack in 1; i_reg_rac_rdata in REG_DW.
REQ-010 The block SHALL have port o_rac_ack_tmo_err out 1, a one-cycle pulse on bank timeout.

Function
REQ-011 The block SHALL implement FSM states IDLE, BUSY and RESP.
REQ-012 In IDLE with any request present, the block SHALL latch winner, addr, wdata and op, then move to BUSY.
REQ-013 The block SHALL assert o_rac_reg_wr_en or o_rac_reg_rd_en for exactly the first BUSY cycle, with addr and wdata held stable throughout BUSY.
REQ-014 Arbitration: OWT write SHALL win over OWT read when both are asserted; OWT SHALL win over WDG, except as stated in REQ-015.
REQ-015 Starvation guard: a counter SHALL increment on each OWT grant while WDG is requesting; when the counter equals STARVE_TH, WDG SHALL win.
REQ-016 The starvation counter SHALL clear on a WDG grant or whenever the WDG request is low in IDLE.
REQ-017 In BUSY, i_reg_rac_ack SHALL be accepted from the first BUSY cycle onward; on acceptance, the block SHALL capture i_reg_rac_rdata (read) and go to RESP.
REQ-018 A BUSY cycle counter SHALL run; if it reaches ACK_TMO_TH-1 without an acknowledge, the block SHALL go to RESP with captured data 0 and pulse o_rac_ack_tmo_err in the RESP cycle.
REQ-019 RESP SHALL last one cycle and pulse only the winner's ack; rdata/data SHALL be valid in that cycle and hold until the next capture; the next state SHALL be IDLE.
REQ-020 o_rac_wdg_scan_crc SHALL equal the CRC over {1'b1, latched addr, captured data}; on timeout it SHALL be the bitwise inverse, guaranteeing a WDG CRC error.
REQ-021 Minimum latency: request seen in IDLE at cycle 0 -> enable at cycle 1 -> ack at cycle 1 -> requester ack at cycle 2.
REQ-022 Requesters drop their request after ack; a request still high in the IDLE cycle following RESP SHALL be treated as a new request.
REQ-023 An ack arriving outside BUSY SHALL be ignored.

Reset
REQ-024 Asynchronous reset SHALL force IDLE and clear all outputs, counters and latches to 0, including mid-BUSY; no ack SHALL be issued for an aborted access.

Structure
REQ-025 REG_AW, REG_DW, REG_CRC_W, the state enum, and the ACK_TMO_TH and STARVE_TH defaults SHALL reside in the shared HV parameter package.
REQ-026 CRC generation SHALL instantiate the existing combinational sub-module crc16to8_parallel.

Verification
REQ-027 WDG read of addr 0x5B, bank acks at cycle 1 with 0xA5 -> o_rac_wdg_scan_ack at cycle 2, data 0xA5, crc equal to the crc16to8 of {1, 0x5B, 0xA5}.
REQ-028 OWT write and WDG read in the same IDLE cycle -> OWT write granted first (wr_en, addr, wdata checked), WDG served immediately after.
REQ-029 OWT requests back-to-back with WDG pending -> WDG granted on the 5th arbitration; counter cleared afterwards.
REQ-030 Bank never acks -> after 16 BUSY cycles, tmo_err and the winner ack pulse together; WDG data 0, crc inverted.
REQ-031 Reset asserted in BUSY -> all outputs 0 immediately; the first post-reset request is served normally.
REQ-032 Stray i_reg_rac_ack in IDLE and OWT wr+rd both high -> no response to the stray ack; the write is performed.

Source files
------------

// File: rtl/hv_reg_acc_arb_pkg.sv
// Shared HV parameter package: register-access widths, arbiter defaults,
// response CRC polynomial and the arbiter FSM/winner enums.
package hv_reg_acc_arb_pkg;

   localparam int REG_AW     = 7;
   localparam int REG_DW     = 8;
   localparam int REG_CRC_W  = 8;
   localparam int ACK_TMO_TH = 16;
   localparam int STARVE_TH  = 4;

   // CRC-8 generator x^8 + x^2 + x + 1, MSB first, zero initial value
   localparam logic [7:0] CRC_POLY = 8'h07;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } racState_e;

   typedef enum logic {
      WIN_OWT = 1'b0,
      WIN_WDG = 1'b1
   } racWinner_e;

endpackage

// File: rtl/crc16to8_parallel.sv
// Combinational CRC over a DIN_W-bit word, fully unrolled into one cycle.
module crc16to8_parallel
   import hv_reg_acc_arb_pkg::*;
#(
   parameter int               DIN_W = 16,
   parameter int               CRC_W = 8,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'(CRC_POLY)
) (
   input  logic [DIN_W-1:0] i_data,
   output logic [CRC_W-1:0] o_crc
);

   logic [CRC_W-1:0] crcAcc;
   logic             feedback;

   // Unrolled MSB-first LFSR with zero seed and no final XOR
   always_comb begin
      crcAcc   = '0;
      feedback = 1'b0;
      for (int i = DIN_W - 1; i >= 0; i--) begin
         feedback = crcAcc[CRC_W-1] ^ i_data[i];
         crcAcc   = {crcAcc[CRC_W-2:0], 1'b0};
         if (feedback) begin
            crcAcc = crcAcc ^ POLY;
         end
      end
      o_crc = crcAcc;
   end

endmodule

// File: rtl/hv_reg_acc_arb.sv
// Register-access arbiter: serialises OWT read/write and WDG scan reads onto
// one register bank, with a starvation guard for WDG and an ack timeout.
module hv_reg_acc_arb
   import hv_reg_acc_arb_pkg::*;
#(
   parameter int REG_AW     = hv_reg_acc_arb_pkg::REG_AW,
   parameter int REG_DW     = hv_reg_acc_arb_pkg::REG_DW,
   parameter int REG_CRC_W  = hv_reg_acc_arb_pkg::REG_CRC_W,
   parameter int ACK_TMO_TH = hv_reg_acc_arb_pkg::ACK_TMO_TH,
   parameter int STARVE_TH  = hv_reg_acc_arb_pkg::STARVE_TH
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_owt_rac_wr_req,
   input  logic                 i_owt_rac_rd_req,
   input  logic [REG_AW-1:0]    i_owt_rac_addr,
   input  logic [REG_DW-1:0]    i_owt_rac_wdata,
   output logic                 o_rac_owt_ack,
   output logic [REG_DW-1:0]    o_rac_owt_rdata,
   input  logic                 i_wdg_scan_rac_rd_req,
   input  logic [REG_AW-1:0]    i_wdg_scan_rac_addr,
   output logic                 o_rac_wdg_scan_ack,
   output logic [REG_DW-1:0]    o_rac_wdg_scan_data,
   output logic [REG_CRC_W-1:0] o_rac_wdg_scan_crc,
   output logic                 o_rac_reg_wr_en,
   output logic                 o_rac_reg_rd_en,
   output logic [REG_AW-1:0]    o_rac_reg_addr,
   output logic [REG_DW-1:0]    o_rac_reg_wdata,
   input  logic                 i_reg_rac_ack,
   input  logic [REG_DW-1:0]    i_reg_rac_rdata,
   output logic                 o_rac_ack_tmo_err
);

   localparam int TMO_W = (ACK_TMO_TH > 1) ? $clog2(ACK_TMO_TH) : 1;
   localparam int STV_W = $clog2(STARVE_TH + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO_TH - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_TH);

   racState_e              state_q;
   racWinner_e             winner_q;
   logic                   opWrite_q;
   logic [REG_AW-1:0]      addr_q;
   logic [REG_DW-1:0]      wdata_q;
   logic [REG_DW-1:0]      data_q;
   logic [REG_CRC_W-1:0]   crc_q;
   logic [TMO_W-1:0]       busyCnt_q;
   logic [STV_W-1:0]       starveCnt_q;
   logic                   wrEn_q;
   logic                   rdEn_q;
   logic                   owtAck_q;
   logic                   wdgAck_q;
   logic                   tmoErr_q;

   logic                   owtAny;
   logic                   reqAny;
   logic                   grantWdg;
   logic                   accept;
   logic                   timeout;
   logic [REG_DW-1:0]      captureData;
   logic [REG_AW+REG_DW:0] crcIn;
   logic [REG_CRC_W-1:0]   crcRaw;

   // Arbitration decision and bank-completion detection for the current cycle
   always_comb begin
      owtAny      = i_owt_rac_wr_req | i_owt_rac_rd_req;
      reqAny      = owtAny | i_wdg_scan_rac_rd_req;
      grantWdg    = i_wdg_scan_rac_rd_req & (~owtAny | (starveCnt_q == STV_MAX));
      accept      = (state_q == BUSY) & i_reg_rac_ack;
      timeout     = (state_q == BUSY) & ~i_reg_rac_ack & (busyCnt_q == TMO_LAST);
      captureData = timeout ? '0 : i_reg_rac_rdata;
      crcIn       = {1'b1, addr_q, captureData};
   end

   crc16to8_parallel #(
      .DIN_W (REG_AW + REG_DW + 1),
      .CRC_W (REG_CRC_W)
   ) u_crc (
      .i_data (crcIn),
      .o_crc  (crcRaw)
   );

   // Access FSM: latch the winner in IDLE, strobe the bank once, wait for ack
   // or timeout, then pulse the winner's ack for one RESP cycle
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         winner_q    <= WIN_OWT;
         opWrite_q   <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         data_q      <= '0;
         crc_q       <= '0;
         busyCnt_q   <= '0;
         starveCnt_q <= '0;
         wrEn_q      <= 1'b0;
         rdEn_q      <= 1'b0;
         owtAck_q    <= 1'b0;
         wdgAck_q    <= 1'b0;
         tmoErr_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (!i_wdg_scan_rac_rd_req) begin
                  starveCnt_q <= '0;
               end
               if (reqAny) begin
                  busyCnt_q <= '0;
                  state_q   <= BUSY;
                  if (grantWdg) begin
                     winner_q    <= WIN_WDG;
                     opWrite_q   <= 1'b0;
                     addr_q      <= i_wdg_scan_rac_addr;
                     wdata_q     <= '0;
                     rdEn_q      <= 1'b1;
                     starveCnt_q <= '0;
                  end else begin
                     winner_q  <= WIN_OWT;
                     opWrite_q <= i_owt_rac_wr_req;
                     addr_q    <= i_owt_rac_addr;
                     wdata_q   <= i_owt_rac_wdata;
                     wrEn_q    <= i_owt_rac_wr_req;
                     rdEn_q    <= ~i_owt_rac_wr_req;
                     if (i_wdg_scan_rac_rd_req) begin
                        starveCnt_q <= starveCnt_q + 1'b1;
                     end
                  end
               end
            end
            BUSY: begin
               wrEn_q    <= 1'b0;
               rdEn_q    <= 1'b0;
               busyCnt_q <= busyCnt_q + 1'b1;
               if (accept || timeout) begin
                  state_q  <= RESP;
                  owtAck_q <= (winner_q == WIN_OWT);
                  wdgAck_q <= (winner_q == WIN_WDG);
                  tmoErr_q <= timeout;
                  if (timeout || !opWrite_q) begin
                     data_q <= captureData;
                     crc_q  <= timeout ? ~crcRaw : crcRaw;
                  end
               end
            end
            RESP: begin
               owtAck_q <= 1'b0;
               wdgAck_q <= 1'b0;
               tmoErr_q <= 1'b0;
               state_q  <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign o_rac_owt_ack       = owtAck_q;
   assign o_rac_owt_rdata     = data_q;
   assign o_rac_wdg_scan_ack  = wdgAck_q;
   assign o_rac_wdg_scan_data = data_q;
   assign o_rac_wdg_scan_crc  = crc_q;
   assign o_rac_reg_wr_en     = wrEn_q;
   assign o_rac_reg_rd_en     = rdEn_q;
   assign o_rac_reg_addr      = addr_q;
   assign o_rac_reg_wdata     = wdata_q;
   assign o_rac_ack_tmo_err   = tmoErr_q;

endmodule

// File: tb/tb_hv_reg_acc_arb.sv
// Directed self-checking bench for hv_reg_acc_arb with a response scoreboard
// and a behavioural register bank that can be muted to force timeouts.
module tb_hv_reg_acc_arb;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_owt_rac_wr_req;
   logic       i_owt_rac_rd_req;
   logic [6:0] i_owt_rac_addr;
   logic [7:0] i_owt_rac_wdata;
   logic       o_rac_owt_ack;
   logic [7:0] o_rac_owt_rdata;
   logic       i_wdg_scan_rac_rd_req;
   logic [6:0] i_wdg_scan_rac_addr;
   logic       o_rac_wdg_scan_ack;
   logic [7:0] o_rac_wdg_scan_data;
   logic [7:0] o_rac_wdg_scan_crc;
   logic       o_rac_reg_wr_en;
   logic       o_rac_reg_rd_en;
   logic [6:0] o_rac_reg_addr;
   logic [7:0] o_rac_reg_wdata;
   logic       i_reg_rac_ack;
   logic [7:0] i_reg_rac_rdata;
   logic       o_rac_ack_tmo_err;

   typedef struct {
      bit         isWdg;
      bit         chkData;
      logic [7:0] data;
      logic [7:0] crc;
      bit         tmo;
   } expResp_t;

   expResp_t   expQ[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] regMem [0:127];
   bit         bankMute = 1'b0;
   logic [6:0] lastWrAddr = '0;
   logic [7:0] lastWrData = '0;

   hv_reg_acc_arb dut (
      .i_clk                 (i_clk),
      .i_rst_n               (i_rst_n),
      .i_owt_rac_wr_req      (i_owt_rac_wr_req),
      .i_owt_rac_rd_req      (i_owt_rac_rd_req),
      .i_owt_rac_addr        (i_owt_rac_addr),
      .i_owt_rac_wdata       (i_owt_rac_wdata),
      .o_rac_owt_ack         (o_rac_owt_ack),
      .o_rac_owt_rdata       (o_rac_owt_rdata),
      .i_wdg_scan_rac_rd_req (i_wdg_scan_rac_rd_req),
      .i_wdg_scan_rac_addr   (i_wdg_scan_rac_addr),
      .o_rac_wdg_scan_ack    (o_rac_wdg_scan_ack),
      .o_rac_wdg_scan_data   (o_rac_wdg_scan_data),
      .o_rac_wdg_scan_crc    (o_rac_wdg_scan_crc),
      .o_rac_reg_wr_en       (o_rac_reg_wr_en),
      .o_rac_reg_rd_en       (o_rac_reg_rd_en),
      .o_rac_reg_addr        (o_rac_reg_addr),
      .o_rac_reg_wdata       (o_rac_reg_wdata),
      .i_reg_rac_ack         (i_reg_rac_ack),
      .i_reg_rac_rdata       (i_reg_rac_rdata),
      .o_rac_ack_tmo_err     (o_rac_ack_tmo_err)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   // CRC-8 (poly 0x107) as polynomial long division of msg * x^8
   function automatic logic [7:0] crcModel(input logic [15:0] msg);
      logic [23:0] r;
      r = {msg, 8'h00};
      for (int i = 23; i >= 8; i--) begin
         if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
      end
      return r[7:0];
   endfunction

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input bit owtWr, input bit owtRd, input logic [6:0] owtAddr,
                                input logic [7:0] owtData, input bit wdgRd, input logic [6:0] wdgAddr);
      i_owt_rac_wr_req      = owtWr;
      i_owt_rac_rd_req      = owtRd;
      i_owt_rac_addr        = owtAddr;
      i_owt_rac_wdata       = owtData;
      i_wdg_scan_rac_rd_req = wdgRd;
      i_wdg_scan_rac_addr   = wdgAddr;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_outs"},
                  {o_rac_owt_ack, o_rac_wdg_scan_ack, o_rac_reg_wr_en, o_rac_reg_rd_en, o_rac_ack_tmo_err},
                  32'h0);
      checkOutput({tag, "_addr"}, o_rac_reg_addr, 32'h0);
      checkOutput({tag, "_wdata"}, o_rac_reg_wdata, 32'h0);
      checkOutput({tag, "_data"}, {o_rac_owt_rdata, o_rac_wdg_scan_data, o_rac_wdg_scan_crc}, 32'h0);
   endtask

   task automatic waitGrant(input int budget, input logic [6:0] expAddr, input bit expWr);
      int n;
      bit seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         tick();
         n++;
         if (o_rac_reg_wr_en || o_rac_reg_rd_en) seen = 1'b1;
      end
      checkOutput("grant_seen", seen, 1);
      if (seen) begin
         checkOutput("grant_addr", o_rac_reg_addr, expAddr);
         checkOutput("grant_wr", o_rac_reg_wr_en, expWr);
         checkOutput("grant_rd", o_rac_reg_rd_en, !expWr);
      end
   endtask

   task automatic waitResp(input int budget, input int expLat);
      int       n;
      bit       seen;
      expResp_t e;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         tick();
         n++;
         if (o_rac_owt_ack || o_rac_wdg_scan_ack) seen = 1'b1;
      end
      checkOutput("resp_seen", seen, 1);
      if (!seen) return;
      checkOutput("resp_latency", n, expLat);
      checkOutput("sb_nonempty", expQ.size() != 0, 1);
      if (expQ.size() == 0) return;
      e = expQ.pop_front();
      checkOutput("resp_owt_ack", o_rac_owt_ack, !e.isWdg);
      checkOutput("resp_wdg_ack", o_rac_wdg_scan_ack, e.isWdg);
      checkOutput("resp_tmo", o_rac_ack_tmo_err, e.tmo);
      if (e.isWdg) begin
         checkOutput("wdg_data", o_rac_wdg_scan_data, e.data);
         checkOutput("wdg_crc", o_rac_wdg_scan_crc, e.crc);
      end else if (e.chkData) begin
         checkOutput("owt_rdata", o_rac_owt_rdata, e.data);
      end
   endtask

   // Behavioural register bank: acks in the first BUSY cycle unless muted
   initial begin
      i_reg_rac_ack   = 1'b0;
      i_reg_rac_rdata = 8'h00;
      forever begin
         @(posedge i_clk);
         #2;
         if (i_rst_n && !bankMute && (o_rac_reg_rd_en || o_rac_reg_wr_en)) begin
            if (o_rac_reg_wr_en) begin
               regMem[o_rac_reg_addr] = o_rac_reg_wdata;
               lastWrAddr             = o_rac_reg_addr;
               lastWrData             = o_rac_reg_wdata;
               i_reg_rac_rdata        = 8'h00;
            end else begin
               i_reg_rac_rdata = regMem[o_rac_reg_addr];
            end
            i_reg_rac_ack = 1'b1;
            @(posedge i_clk);
            #2;
            i_reg_rac_ack = 1'b0;
         end
      end
   end

   // Absolute time guard so the run always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

   // Directed sequence
   initial begin
      i_rst_n = 1'b0;
      applyStimulus(0, 0, 7'h00, 8'h00, 0, 7'h00);
      tick();
      tick();
      checkAllZero("reset");
      i_rst_n = 1'b1;
      tick();

      // WDG read of 0x5B, minimum latency
      regMem[7'h5B] = 8'hA5;
      expQ.push_back('{1'b1, 1'b1, 8'hA5, crcModel({1'b1, 7'h5B, 8'hA5}), 1'b0});
      applyStimulus(0, 0, 7'h00, 8'h00, 1, 7'h5B);
      waitGrant(1, 7'h5B, 0);
      applyStimulus(0, 0, 7'h00, 8'h00, 0, 7'h00);
      waitResp(1, 1);
      tick();
      checkOutput("ack_pulse_end", {o_rac_owt_ack, o_rac_wdg_scan_ack}, 0);

      // OWT write and WDG read together: write first, WDG right after
      regMem[7'h20] = 8'h6C;
      expQ.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
      expQ.push_back('{1'b1, 1'b1, 8'h6C, crcModel({1'b1, 7'h20, 8'h6C}), 1'b0});
      applyStimulus(1, 0, 7'h12, 8'h3C, 1, 7'h20);
      waitGrant(1, 7'h12, 1);
      checkOutput("wr_wdata", o_rac_reg_wdata, 8'h3C);
      applyStimulus(0, 0, 7'h00, 8'h00, 1, 7'h20);
      waitResp(1, 1);
      waitGrant(2, 7'h20, 0);
      applyStimulus(0, 0, 7'h00, 8'h00, 0, 7'h00);
      waitResp(1, 1);
      checkOutput("bank_wr_addr", lastWrAddr, 7'h12);
      checkOutput("bank_wr_data", lastWrData, 8'h3C);
      tick();

      // Back-to-back OWT reads with WDG pending: WDG wins every 5th arbitration
      regMem[7'h30] = 8'h31;
      regMem[7'h40] = 8'h41;
      applyStimulus(0, 1, 7'h30, 8'h00, 1, 7'h40);
      for (int i = 0; i < 10; i++) begin
         bit isW;
         isW = (i == 4) || (i == 9);
         if (isW) expQ.push_back('{1'b1, 1'b1, 8'h41, crcModel({1'b1, 7'h40, 8'h41}), 1'b0});
         else     expQ.push_back('{1'b0, 1'b1, 8'h31, 8'h00, 1'b0});
         waitGrant(3, isW ? 7'h40 : 7'h30, 0);
         waitResp(2, 1);
      end
      applyStimulus(0, 0, 7'h00, 8'h00, 0, 7'h00);
      tick();
      tick();

      // Bank never acks: timeout after 16 BUSY cycles, WDG crc inverted
      bankMute = 1'b1;
      expQ.push_back('{1'b1, 1'b1, 8'h00, ~crcModel({1'b1, 7'h11, 8'h00}), 1'b1});
      applyStimulus(0, 0, 7'h00, 8'h00, 1, 7'h11);
      waitGrant(1, 7'h11, 0);
      applyStimulus(0, 0, 7'h00, 8'h00, 0, 7'h00);
      tick();
      checkOutput("rd_en_one_cycle", o_rac_reg_rd_en, 0);
      checkOutput("addr_stable", o_rac_reg_addr, 7'h11);
      waitResp(20, 15);
      tick();
      checkOutput("tmo_pulse_end", {o_rac_ack_tmo_err, o_rac_wdg_scan_ack}, 0);

      // Reset in the middle of BUSY, then a normal access
      applyStimulus(0, 1, 7'h22, 8'h00, 0, 7'h00);
      waitGrant(1, 7'h22, 0);
      tick();
      #1;
      i_rst_n = 1'b0;
      #1;
      checkAllZero("mid_busy_reset");
      applyStimulus(0, 0, 7'h00, 8'h00, 0, 7'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("no_ack_after_abort", {o_rac_owt_ack, o_rac_wdg_scan_ack}, 0);
      end
      i_rst_n  = 1'b1;
      bankMute = 1'b0;
      tick();
      regMem[7'h22] = 8'h99;
      expQ.push_back('{1'b0, 1'b1, 8'h99, 8'h00, 1'b0});
      applyStimulus(0, 1, 7'h22, 8'h00, 0, 7'h00);
      waitGrant(1, 7'h22, 0);
      applyStimulus(0, 0, 7'h00, 8'h00, 0, 7'h00);
      waitResp(1, 1);
      tick();

      // Stray bank ack in IDLE is ignored; wr+rd together performs the write
      i_reg_rac_ack   = 1'b1;
      i_reg_rac_rdata = 8'hEE;
      for (int i = 0; i < 2; i++) begin
         tick();
         checkOutput("stray_ack_ignored",
                     {o_rac_owt_ack, o_rac_wdg_scan_ack, o_rac_reg_wr_en, o_rac_reg_rd_en}, 0);
      end
      i_reg_rac_ack = 1'b0;
      expQ.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 1'b0});
      applyStimulus(1, 1, 7'h55, 8'h77, 0, 7'h00);
      waitGrant(1, 7'h55, 1);
      checkOutput("wrrd_wdata", o_rac_reg_wdata, 8'h77);
      applyStimulus(0, 0, 7'h00, 8'h00, 0, 7'h00);
      waitResp(1, 1);
      checkOutput("wrrd_bank_addr", lastWrAddr, 7'h55);
      checkOutput("wrrd_bank_data", lastWrData, 8'h77);
      checkOutput("sb_drained", expQ.size(), 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
